// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared VGA timing constants and helpers. The default 640x480
//               timing lives here so that the sync generator and the
//               graphic-side modules agree on screen limits and totals.
//
//               Contents:
//                 VGA_CLK_DIV        system clocks per pixel (default 4)
//                 VGA_H_* / VGA_V_*  horizontal (pixels) / vertical (lines)
//                 VGA_H_TOTAL        pixels per line, including blanking
//                 VGA_V_TOTAL        lines per frame, including blanking
//                 coord_t            pixel column / row coordinate type
//                 sync_t             packed pair of active-low sync levels
//                 in_window()        half-open range test lo <= v < hi
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int unsigned VGA_CLK_DIV   = 4;

    localparam int unsigned VGA_H_DISPLAY = 640;
    localparam int unsigned VGA_H_FP      = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BP      = 48;

    localparam int unsigned VGA_V_DISPLAY = 480;
    localparam int unsigned VGA_V_FP      = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BP      = 33;

    localparam int unsigned VGA_H_TOTAL =
        VGA_H_DISPLAY + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_V_TOTAL =
        VGA_V_DISPLAY + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // 11 bits covers every total up to 2047, ample for any VGA-class mode.
    localparam int unsigned COORD_W = 11;

    typedef logic [COORD_W-1:0] coord_t;

    // Both sync outputs are active low; the idle value of this struct is 2'b11.
    typedef struct packed {
        logic hsync;
        logic vsync;
    } sync_t;

    // Half-open window test used for the sync pulse regions.
    function automatic logic in_window(input coord_t v,
                                       input coord_t lo,
                                       input coord_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vga_pixel_div.sv
`default_nettype none
// ============================================================================
// Module      : vga_pixel_div
// Description : Pixel clock-enable generator. A free-running divider counts
//               0..CLK_DIV-1 and wraps; pixel_tick is high for the single clk
//               in which the divider sits at its last value, so the registers
//               that consume it advance on every CLK_DIV-th rising edge.
//
//               Ports:
//                 clk         system clock
//                 reset       asynchronous, active-low reset
//                 pixel_tick  one-clk pixel enable strobe
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pixel_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic pixel_tick
);

    // CLK_DIV >= 2, so $clog2 is at least 1 and holds 0..CLK_DIV-1.
    localparam int unsigned        DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Decoded from the counter rather than registered: with the counter
    // cleared by reset the strobe is low for the whole reset period, and the
    // first CLK_DIV-1 edges after release are spent counting up to it.
    assign pixel_tick = (div_cnt == DIV_LAST);

endmodule : vga_pixel_div
`default_nettype wire

// File: rtl/vga_sync.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync
// Description : VGA timing generator. Produces pixel column/row counters, the
//               visible-area flag, a frame-wrap pulse, and registered
//               active-low hsync/vsync plus blanked colour. Sync and colour
//               registers load on the pixel tick from the position *before*
//               it advances, so they trail x/y by exactly one pixel period;
//               this gives the pixel generator CLK_DIV-1 clks to produce
//               rgb_in for the new x/y before it is captured.
//
//               Ports:
//                 clk          system clock
//                 reset        asynchronous, active-low reset
//                 rgb_in[7:0]  colour for the current x,y
//                 x[10:0]      current pixel column
//                 y[10:0]      current pixel row
//                 pixel_tick   one-clk pixel enable strobe
//                 video_on     x,y inside the visible area (combinational)
//                 frame_start  one-clk pulse on the tick that wraps to 0,0
//                 hsync        active-low horizontal sync (registered)
//                 vsync        active-low vertical sync (registered)
//                 rgb[7:0]     registered colour, forced to 0 when blanked
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV   = VGA_CLK_DIV,
    parameter int unsigned H_DISPLAY = VGA_H_DISPLAY,
    parameter int unsigned H_FP      = VGA_H_FP,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BP      = VGA_H_BP,
    parameter int unsigned V_DISPLAY = VGA_V_DISPLAY,
    parameter int unsigned V_FP      = VGA_V_FP,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BP      = VGA_V_BP
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         rgb_in,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               pixel_tick,
    output logic               video_on,
    output logic               frame_start,
    output logic               hsync,
    output logic               vsync,
    output logic [7:0]         rgb
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

    localparam coord_t X_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t Y_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t X_VIS    = coord_t'(H_DISPLAY);
    localparam coord_t Y_VIS    = coord_t'(V_DISPLAY);
    localparam coord_t HS_START = coord_t'(H_DISPLAY + H_FP);
    localparam coord_t HS_END   = coord_t'(H_DISPLAY + H_FP + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_DISPLAY + V_FP);
    localparam coord_t VS_END   = coord_t'(V_DISPLAY + V_FP + V_SYNC);

    localparam sync_t  SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1};

    logic   tick;
    logic   x_last;
    logic   y_last;
    logic   in_hsync;
    logic   in_vsync;
    sync_t  sync_q;
    sync_t  sync_next;

    // ------------------------------------------------------------------------
    // Pixel enable
    // ------------------------------------------------------------------------
    vga_pixel_div #(
        .CLK_DIV    (CLK_DIV)
    ) u_pixel_div (
        .clk        (clk),
        .reset      (reset),
        .pixel_tick (tick)
    );

    assign pixel_tick = tick;

    // ------------------------------------------------------------------------
    // Position counters: x runs 0..H_TOTAL-1, y advances on each x wrap.
    // ------------------------------------------------------------------------
    assign x_last = (x == X_LAST);
    assign y_last = (y == Y_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x <= '0;
            y <= '0;
        end else if (tick) begin
            if (x_last) begin
                x <= '0;
                if (y_last) begin
                    y <= '0;
                end else begin
                    y <= y + 1'b1;
                end
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Decodes on the current (pre-advance) position
    // ------------------------------------------------------------------------
    assign video_on    = (x < X_VIS) && (y < Y_VIS);
    assign frame_start = tick && x_last && y_last;

    assign in_hsync = in_window(x, HS_START, HS_END);
    assign in_vsync = in_window(y, VS_START, VS_END);

    always_comb begin
        sync_next       = SYNC_IDLE;
        sync_next.hsync = ~in_hsync;
        sync_next.vsync = ~in_vsync;
    end

    // ------------------------------------------------------------------------
    // Output registers. Loading them on the same tick that moves x/y is what
    // produces the one-pixel lag: they always describe the pixel just left.
    // Reset returns both syncs to idle so no partial pulse survives it.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= SYNC_IDLE;
            rgb    <= 8'h00;
        end else if (tick) begin
            sync_q <= sync_next;
            rgb    <= video_on ? rgb_in : 8'h00;
        end
    end

    assign hsync = sync_q.hsync;
    assign vsync = sync_q.vsync;

endmodule : vga_sync
`default_nettype wire

// File: tb/tb_vga_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync
// Description : Self-checking bench for vga_sync. Three instances run side by
//               side: default timing at CLK_DIV=4, default timing at
//               CLK_DIV=2, and a miniature mode at CLK_DIV=3 small enough to
//               complete several frames. Every clk, each instance is compared
//               against a reference computed from the number of clk edges
//               since reset release using plain division/modulo of the mode
//               totals. Pulse widths, periods and first-event timing are
//               measured separately and compared with the expected figures.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync;
    import vga_pkg::*;

    typedef struct {
        int unsigned d;
        int unsigned hd, hfp, hs, hbp;
        int unsigned vd, vfp, vs, vbp;
    } tm_t;

    typedef struct {
        logic        tick;
        logic        von;
        logic        fs;
        logic        hs;
        logic        vs;
        logic        pvis;
        int unsigned x;
        int unsigned y;
    } exp_t;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic [7:0] rgb_in = 8'h00;

    logic [2:0][10:0] xo;
    logic [2:0][10:0] yo;
    logic [2:0][7:0]  rgb_o;
    logic [2:0]       tick_o, von_o, fs_o, hs_o, vs_o;

    vga_sync u_dut0 (
        .clk(clk), .reset(reset), .rgb_in(rgb_in),
        .x(xo[0]), .y(yo[0]), .pixel_tick(tick_o[0]), .video_on(von_o[0]),
        .frame_start(fs_o[0]), .hsync(hs_o[0]), .vsync(vs_o[0]), .rgb(rgb_o[0])
    );

    vga_sync #(.CLK_DIV(2)) u_dut1 (
        .clk(clk), .reset(reset), .rgb_in(rgb_in),
        .x(xo[1]), .y(yo[1]), .pixel_tick(tick_o[1]), .video_on(von_o[1]),
        .frame_start(fs_o[1]), .hsync(hs_o[1]), .vsync(vs_o[1]), .rgb(rgb_o[1])
    );

    vga_sync #(
        .CLK_DIV(3),
        .H_DISPLAY(20), .H_FP(4), .H_SYNC(6), .H_BP(5),
        .V_DISPLAY(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u_dut2 (
        .clk(clk), .reset(reset), .rgb_in(rgb_in),
        .x(xo[2]), .y(yo[2]), .pixel_tick(tick_o[2]), .video_on(von_o[2]),
        .frame_start(fs_o[2]), .hsync(hs_o[2]), .vsync(vs_o[2]), .rgb(rgb_o[2])
    );

    always #5 clk = ~clk;

    tm_t         tm [3];
    exp_t        ex [3];
    logic [7:0]  cap[3];
    int unsigned k      = 0;
    int          cyc    = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        chk_en  = 1'b0;
    logic        meas_en = 1'b0;
    logic        fixed   = 1'b0;

    // measurement state per instance
    logic prev_hs[3], prev_vs[3];
    int   tk1[3], tk2[3], ticks_seen[3], ff_ticks[3];
    int   hf1[3], hf2[3], hs_run[3], hs_w[3];
    int   vs_run[3], vs_w[3];
    int   fs1[3], fs2[3], fs_run[3], fs_w[3];

    // Reference: after kk edges since release, kk/d pixel ticks have fired.
    // Position is that tick count modulo the frame; the sync/colour registers
    // describe the position of the previous tick.
    function automatic exp_t model(input tm_t t, input int unsigned kk);
        exp_t        e;
        int unsigned ht, vt, frame, tt, p, q, xq, yq;
        ht    = t.hd + t.hfp + t.hs + t.hbp;
        vt    = t.vd + t.vfp + t.vs + t.vbp;
        frame = ht * vt;
        tt    = kk / t.d;
        e.tick = ((kk % t.d) == t.d - 1);
        p     = tt % frame;
        e.x   = p % ht;
        e.y   = p / ht;
        e.von = (e.x < t.hd) && (e.y < t.vd);
        e.fs  = e.tick && (e.x == ht - 1) && (e.y == vt - 1);
        if (tt == 0) begin
            e.hs = 1'b1; e.vs = 1'b1; e.pvis = 1'b0;
        end else begin
            q  = (tt - 1) % frame;
            xq = q % ht;
            yq = q / ht;
            e.hs   = !((xq >= t.hd + t.hfp) && (xq < t.hd + t.hfp + t.hs));
            e.vs   = !((yq >= t.vd + t.vfp) && (yq < t.vd + t.vfp + t.vs));
            e.pvis = (xq < t.hd) && (yq < t.vd);
        end
        return e;
    endfunction

    task automatic chk(input string tag, input int inst,
                       input longint obs, input longint expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s[dut%0d] got=%0d exp=%0d at t=%0t",
                     tag, inst, obs, expv, $time);
        end
    endtask

    task automatic measure(input int i);
        if (tick_o[i]) begin
            if (tk1[i] < 0)      tk1[i] = int'(k);
            else if (tk2[i] < 0) tk2[i] = int'(k);
        end
        if (!hs_o[i]) begin
            if (prev_hs[i]) begin
                if (hf1[i] < 0) begin
                    hf1[i] = cyc; ff_ticks[i] = ticks_seen[i];
                end else if (hf2[i] < 0) begin
                    hf2[i] = cyc;
                end
            end
            hs_run[i]++;
        end else begin
            if (hs_run[i] > 0 && hs_w[i] < 0) hs_w[i] = hs_run[i];
            hs_run[i] = 0;
        end
        if (!vs_o[i]) begin
            vs_run[i]++;
        end else begin
            if (vs_run[i] > 0 && vs_w[i] < 0) vs_w[i] = vs_run[i];
            vs_run[i] = 0;
        end
        if (fs_o[i]) begin
            if (fs_run[i] == 0) begin
                if (fs1[i] < 0)      fs1[i] = cyc;
                else if (fs2[i] < 0) fs2[i] = cyc;
            end
            fs_run[i]++;
        end else begin
            if (fs_run[i] > 0 && fs_w[i] < 0) fs_w[i] = fs_run[i];
            fs_run[i] = 0;
        end
        if (tick_o[i]) ticks_seen[i]++;
        prev_hs[i] = hs_o[i];
        prev_vs[i] = vs_o[i];
    endtask

    // One clk: sample on the falling edge, compare, then drive the next input.
    task automatic step();
        @(negedge clk);
        if (reset) k++;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            ex[i] = model(tm[i], k);
            if (chk_en) begin
                chk("x",           i, xo[i],     ex[i].x);
                chk("y",           i, yo[i],     ex[i].y);
                chk("pixel_tick",  i, tick_o[i], ex[i].tick);
                chk("video_on",    i, von_o[i],  ex[i].von);
                chk("frame_start", i, fs_o[i],   ex[i].fs);
                chk("hsync",       i, hs_o[i],   ex[i].hs);
                chk("vsync",       i, vs_o[i],   ex[i].vs);
                chk("rgb",         i, rgb_o[i],  ex[i].pvis ? cap[i] : 8'h00);
            end
            if (meas_en) measure(i);
        end
        rgb_in = fixed ? 8'hD0 : 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            if (ex[i].tick) cap[i] = rgb_in;
        end
    endtask

    initial begin
        int   line_clk;
        logic found;

        tm[0] = '{4, 640, 16, 96, 48, 480, 10, 2, 33};
        tm[1] = '{2, 640, 16, 96, 48, 480, 10, 2, 33};
        tm[2] = '{3, 20, 4, 6, 5, 12, 2, 2, 3};
        for (int i = 0; i < 3; i++) begin
            cap[i] = 8'h00; prev_hs[i] = 1'b1; prev_vs[i] = 1'b1;
            tk1[i] = -1; tk2[i] = -1; ticks_seen[i] = 0; ff_ticks[i] = -1;
            hf1[i] = -1; hf2[i] = -1; hs_run[i] = 0; hs_w[i] = -1;
            vs_run[i] = 0; vs_w[i] = -1;
            fs1[i] = -1; fs2[i] = -1; fs_run[i] = 0; fs_w[i] = -1;
        end

        // Hold reset; the reset state is compared on the later cycles.
        repeat (2) step();
        chk_en = 1'b1;
        repeat (3) step();

        // Release and free-run while measuring pulse timing.
        #1 reset = 1'b1;
        meas_en = 1'b1;
        repeat (7000) step();
        meas_en = 1'b0;

        for (int i = 0; i < 3; i++) begin
            line_clk = int'((tm[i].hd + tm[i].hfp + tm[i].hs + tm[i].hbp) * tm[i].d);
            chk("first_tick_clk",   i, tk1[i] + 1, tm[i].d);
            chk("tick_spacing",     i, tk2[i] - tk1[i], tm[i].d);
            chk("first_hfall_tick", i, ff_ticks[i], tm[i].hd + tm[i].hfp + 1);
            chk("hfall_spacing",    i, hf2[i] - hf1[i], line_clk);
            chk("hsync_low_clks",   i, hs_w[i], tm[i].hs * tm[i].d);
        end
        // Figures for the full-size modes stated directly.
        chk("first_tick_clk_abs", 0, tk1[0] + 1, 4);
        chk("hsync_low_abs",      0, hs_w[0], 384);
        chk("line_period_abs",    0, hf2[0] - hf1[0], 3200);
        chk("first_hfall_abs",    0, ff_ticks[0], 657);
        chk("line_period_abs",    1, hf2[1] - hf1[1], 1600);
        chk("hsync_low_abs",      1, hs_w[1], 192);
        // Miniature mode completes whole frames: 35x19 pixels at 3 clks.
        chk("vsync_low_clks",     2, vs_w[2], 2 * 35 * 3);
        chk("frame_period",       2, fs2[2] - fs1[2], 35 * 19 * 3);
        chk("frame_start_width",  2, fs_w[2], 1);

        // Assert reset mid-line while dut0 sits inside its hsync pulse.
        found = 1'b0;
        for (int n = 0; n < 4000 && !found; n++) begin
            step();
            if (xo[0] == 11'd700) found = 1'b1;
        end
        chk("wait_x700", 0, found, 1);
        #1 reset = 1'b0;
        k = 0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_x",     i, xo[i], 0);
            chk("rst_y",     i, yo[i], 0);
            chk("rst_rgb",   i, rgb_o[i], 0);
            chk("rst_hsync", i, hs_o[i], 1);
            chk("rst_vsync", i, vs_o[i], 1);
            chk("rst_tick",  i, tick_o[i], 0);
            chk("rst_fs",    i, fs_o[i], 0);
        end
        repeat (3) step();

        // Restart with a constant colour to exercise blanking of a flat field.
        fixed = 1'b1;
        #1 reset = 1'b1;
        repeat (8000) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_vga_sync
`default_nettype wire
